// File: rtl/irq_exception_sequencer_if.sv
// irq_exception_sequencer_if: pipeline/coprocessor-0 exception signals between sequencer and its environment
interface irq_exception_sequencer_if #(parameter int NUM_IRQ = 4);
  logic [NUM_IRQ-1:0] irq_i;
  logic [31:0]        pc_i;
  logic               pc_valid_i;
  logic               syscall_i;
  logic               eret_i;
  logic               int_en_i;
  logic [31:0]        epc_i;
  logic [31:0]        epc_w_o;
  logic [4:0]         cause_o;
  logic               write_epc_o;
  logic               write_cause_o;
  logic               write_int_o;
  logic               int_en_w_o;
  logic               stall_o;
  logic               redirect_o;
  logic [31:0]        redirect_pc_o;
  logic [NUM_IRQ-1:0] irq_ack_o;
  modport master (
    input  irq_i, pc_i, pc_valid_i, syscall_i, eret_i, int_en_i, epc_i,
    output epc_w_o, cause_o, write_epc_o, write_cause_o, write_int_o, int_en_w_o,
           stall_o, redirect_o, redirect_pc_o, irq_ack_o
  );
  modport slave (
    output irq_i, pc_i, pc_valid_i, syscall_i, eret_i, int_en_i, epc_i,
    input  epc_w_o, cause_o, write_epc_o, write_cause_o, write_int_o, int_en_w_o,
           stall_o, redirect_o, redirect_pc_o, irq_ack_o
  );
endinterface

// File: rtl/irq_exception_sequencer.sv
// irq_exception_sequencer: sequences coprocessor-0 strobes and fetch redirects for irq/syscall/eret
module irq_exception_sequencer #(
  parameter int          NUM_IRQ       = 4,
  parameter logic [31:0] VECTOR_ADDR   = 32'h0000_0008,
  parameter logic [4:0]  SYSCALL_CAUSE = 5'd8
) (
  input logic clk,
  input logic rst,
  irq_exception_sequencer_if.master bus
);
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SAVE     = 3'd1;
  localparam logic [2:0] MASK     = 3'd2;
  localparam logic [2:0] JUMP     = 3'd3;
  localparam logic [2:0] RET_EN   = 3'd4;
  localparam logic [2:0] RET_JUMP = 3'd5;
  logic [2:0]         state_q, state_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d, irq_dly_q, irq_dly_d, ack;
  logic [31:0]        pc_q, pc_d, rpc_q, rpc_d;
  logic [4:0]         cause_q, cause_d;
  logic [2:0]         idx_q, idx_d, sel;
  logic               is_irq_q, is_irq_d;
  // lowest-index pending line and the one-hot acknowledge of the line being serviced
  always_comb begin
    sel = '0;
    ack = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      sel    = pending_q[k] ? 3'(k) : sel;
      ack[k] = state_q == JUMP && is_irq_q && idx_q == 3'(k);
    end
  end
  // next state: edge latching always runs, acceptance only from IDLE with eret > syscall > irq
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    cause_d   = cause_q;
    idx_d     = idx_q;
    is_irq_d  = is_irq_q;
    irq_dly_d = bus.irq_i;
    pending_d = (pending_q & ~ack) | (bus.irq_i & ~irq_dly_q);
    rpc_d     = state_q == JUMP ? VECTOR_ADDR : state_q == RET_JUMP ? bus.epc_i : rpc_q;
    if (state_q != IDLE) begin
      state_d = state_q == SAVE ? MASK : state_q == MASK ? JUMP : state_q == RET_EN ? RET_JUMP : IDLE;
    end else if (bus.pc_valid_i && bus.eret_i) begin
      state_d = RET_EN;
    end else if (bus.pc_valid_i && bus.syscall_i) begin
      state_d  = SAVE;
      pc_d     = bus.pc_i + 32'd4;
      cause_d  = SYSCALL_CAUSE;
      is_irq_d = 1'b0;
    end else if (bus.pc_valid_i && bus.int_en_i && |pending_q) begin
      state_d  = SAVE;
      pc_d     = bus.pc_i;
      cause_d  = 5'b10000 | {2'b00, sel};
      idx_d    = sel;
      is_irq_d = 1'b1;
    end
  end
  // outputs decode from state; epc/cause/redirect target hold their last values in IDLE
  always_comb begin
    bus.epc_w_o       = pc_q;
    bus.cause_o       = cause_q;
    bus.write_epc_o   = state_q == SAVE;
    bus.write_cause_o = state_q == SAVE;
    bus.write_int_o   = state_q == MASK || state_q == RET_EN;
    bus.int_en_w_o    = state_q == RET_EN;
    bus.stall_o       = state_q != IDLE || state_d != IDLE;
    bus.redirect_o    = state_q == JUMP || state_q == RET_JUMP;
    bus.redirect_pc_o = rpc_d;
    bus.irq_ack_o     = ack;
  end
  // state registers with synchronous reset that aborts any sequence in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      irq_dly_q <= '0;
      pc_q      <= '0;
      rpc_q     <= '0;
      cause_q   <= '0;
      idx_q     <= '0;
      is_irq_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      irq_dly_q <= irq_dly_d;
      pc_q      <= pc_d;
      rpc_q     <= rpc_d;
      cause_q   <= cause_d;
      idx_q     <= idx_d;
      is_irq_q  <= is_irq_d;
    end
  end
endmodule

// File: tb/tb_irq_exception_sequencer.sv
// tb_irq_exception_sequencer: scoreboard bench with directed and random stimulus against a cycle-event model
module tb_irq_exception_sequencer;
  typedef struct {
    int          cyc;
    logic [4:0]  strb;
    logic [31:0] epc;
    logic [4:0]  cause;
    logic [31:0] rpc;
    logic [3:0]  ack;
  } ev_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  irq_exception_sequencer_if #(.NUM_IRQ(4)) bus ();
  irq_exception_sequencer #(.NUM_IRQ(4), .VECTOR_ADDR(32'h8), .SYSCALL_CAUSE(5'd8)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          busy = 0;
  int          ack_at = -1;
  logic [3:0]  ack_mask = '0;
  logic [3:0]  pend = '0;
  logic [3:0]  prev = '0;
  logic        stall_exp = 1'b0;
  bit          chk_en = 0;
  logic [31:0] epc_cur = 32'h0;
  ev_t         q[$];
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask
  function automatic ev_t mk(int c, logic [4:0] s, logic [31:0] e, logic [4:0] ca, logic [31:0] r, logic [3:0] a);
    ev_t v;
    v.cyc = c; v.strb = s; v.epc = e; v.cause = ca; v.rpc = r; v.ack = a;
    return v;
  endfunction
  // model: a taken entry costs three busy cycles (save, mask, jump), a return costs two
  task automatic model_step();
    logic [3:0] rise, clr;
    logic       acc;
    int         k;
    rise = bus.irq_i & ~prev;
    clr  = (cyc == ack_at) ? ack_mask : 4'b0;
    acc  = busy == 0 && bus.pc_valid_i && (bus.eret_i || bus.syscall_i || (pend != 0 && bus.int_en_i));
    stall_exp = busy != 0 || acc;
    if (rst) begin
      while (q.size() > 0 && q[q.size()-1].cyc > cyc) void'(q.pop_back());
      busy = 0; pend = '0; prev = '0; ack_at = -1;
      return;
    end
    if (acc && bus.eret_i) begin
      q.push_back(mk(cyc + 1, 5'b00110, 0, 0, 0, 0));
      q.push_back(mk(cyc + 2, 5'b00001, 0, 0, bus.epc_i, 0));
      busy = 2;
    end else if (acc && bus.syscall_i) begin
      q.push_back(mk(cyc + 1, 5'b11000, bus.pc_i + 32'd4, 5'd8, 0, 0));
      q.push_back(mk(cyc + 2, 5'b00100, 0, 0, 0, 0));
      q.push_back(mk(cyc + 3, 5'b00001, 0, 0, 32'h8, 0));
      busy = 3;
    end else if (acc) begin
      k = 0;
      for (int i = 3; i >= 0; i--) if (pend[i]) k = i;
      q.push_back(mk(cyc + 1, 5'b11000, bus.pc_i, 5'(16 + k), 0, 0));
      q.push_back(mk(cyc + 2, 5'b00100, 0, 0, 0, 0));
      q.push_back(mk(cyc + 3, 5'b00001, 0, 0, 32'h8, 4'(1 << k)));
      ack_at = cyc + 3; ack_mask = 4'(1 << k);
      busy = 3;
    end else if (busy > 0) begin
      busy--;
    end
    pend = (pend & ~clr) | rise;
    prev = bus.irq_i;
  endtask
  task automatic run(input logic [3:0] irq, input logic pv, input logic [31:0] pc, input logic sc,
                     input logic er, input logic ie, input logic r);
    @(posedge clk);
    #1;
    rst = r;
    bus.irq_i = irq; bus.pc_valid_i = pv; bus.pc_i = pc; bus.syscall_i = sc;
    bus.eret_i = er; bus.int_en_i = ie; bus.epc_i = epc_cur;
    model_step();
  endtask
  // monitor: stall every cycle, and any strobe/redirect/ack is matched against the next expected event
  always @(negedge clk) begin : mon
    ev_t        e;
    logic [4:0] strb;
    if (chk_en) begin
      chk("stall", 128'(bus.stall_o), 128'(stall_exp));
      while (q.size() > 0 && q[0].cyc < cyc) begin
        chk("missed_event_cycle", 128'(cyc), 128'(q[0].cyc));
        void'(q.pop_front());
      end
      strb = {bus.write_epc_o, bus.write_cause_o, bus.write_int_o, bus.int_en_w_o, bus.redirect_o};
      if (strb != 0 || bus.irq_ack_o != 0) begin
        if (q.size() == 0) begin
          chk("spurious_event", 128'({strb, bus.irq_ack_o}), 128'(0));
        end else begin
          e = q.pop_front();
          chk("event_cycle", 128'(cyc), 128'(e.cyc));
          chk("strobes_ack", 128'({strb, bus.irq_ack_o}), 128'({e.strb, e.ack}));
          if (e.strb[4]) chk("epc_cause", 128'({bus.epc_w_o, bus.cause_o}), 128'({e.epc, e.cause}));
          if (e.strb[0]) chk("redirect_pc", 128'(bus.redirect_pc_o), 128'(e.rpc));
        end
      end
    end
  end
  initial begin
    bus.irq_i = '0; bus.pc_valid_i = 0; bus.pc_i = '0; bus.syscall_i = 0;
    bus.eret_i = 0; bus.int_en_i = 0; bus.epc_i = '0;
    run(4'b0, 0, 0, 0, 0, 0, 1);
    chk_en = 1;
    repeat (2) run(4'b0, 0, 0, 0, 0, 0, 1);
    run(4'b0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("reset_outputs", 128'({bus.epc_w_o, bus.cause_o, bus.write_epc_o, bus.write_cause_o, bus.write_int_o,
        bus.int_en_w_o, bus.stall_o, bus.redirect_o, bus.redirect_pc_o, bus.irq_ack_o}), 128'(0));
    // single irq on line 2
    repeat (7) run(4'b0100, 1, 32'h100, 0, 0, 1, 0);
    run(4'b0, 0, 0, 0, 0, 1, 0);
    // lines 1 and 2 together: 1 first, 2 after enable returns
    repeat (2) run(4'b0110, 1, 32'h200, 0, 0, 1, 0);
    repeat (6) run(4'b0110, 1, 32'h200, 0, 0, 0, 0);
    repeat (6) run(4'b0110, 1, 32'h200, 0, 0, 1, 0);
    run(4'b0, 0, 0, 0, 0, 0, 0);
    // syscall at the top of memory beats a pending irq and wraps
    repeat (2) run(4'b0001, 0, 0, 0, 0, 0, 0);
    run(4'b0001, 1, 32'hFFFF_FFFC, 1, 0, 1, 0);
    repeat (5) run(4'b0001, 0, 0, 0, 0, 0, 0);
    // eret with the irq still pending
    epc_cur = 32'h204;
    run(4'b0001, 1, 32'h300, 0, 1, 1, 0);
    repeat (4) run(4'b0001, 0, 0, 0, 0, 0, 0);
    repeat (6) run(4'b0001, 1, 32'h400, 0, 0, 1, 0);
    run(4'b0, 0, 0, 0, 0, 0, 0);
    // disabled interrupts keep the line pending
    repeat (11) run(4'b1000, 1, 32'h500, 0, 0, 0, 0);
    repeat (2) run(4'b1000, 0, 32'h500, 0, 0, 1, 0);
    repeat (6) run(4'b1000, 1, 32'h504, 0, 0, 1, 0);
    run(4'b0, 0, 0, 0, 0, 0, 0);
    // reset during MASK
    repeat (3) run(4'b0001, 1, 32'h600, 0, 0, 1, 0);
    run(4'b0, 1, 32'h600, 0, 0, 1, 1);
    run(4'b0, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    chk("abort_outputs", 128'({bus.epc_w_o, bus.cause_o, bus.write_epc_o, bus.write_cause_o, bus.write_int_o,
        bus.int_en_w_o, bus.stall_o, bus.redirect_o, bus.redirect_pc_o, bus.irq_ack_o}), 128'(0));
    repeat (3) run(4'b0, 1, 32'h700, 0, 0, 1, 0);
    // random traffic
    begin
      logic [3:0] irq;
      irq = '0;
      for (int i = 0; i < 3000; i++) begin
        for (int b = 0; b < 4; b++) if ($urandom_range(15) == 0) irq[b] = ~irq[b];
        if (busy == 0 && $urandom_range(3) == 0) epc_cur = $urandom;
        run(irq, $urandom_range(1) == 1, ($urandom_range(7) == 0) ? 32'hFFFF_FFFC : $urandom,
            $urandom_range(9) == 0, $urandom_range(11) == 0, $urandom_range(4) != 0, $urandom_range(299) == 0);
      end
    end
    repeat (6) run(4'b0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("queue_drained", 128'(q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/irq_exception_sequencer.md
Name: irq_exception_sequencer

Overview:
- Initiator side of the coprocessor-0 exception interface. Samples external interrupt lines and the pipeline's syscall/eret requests.
- Sequences the coprocessor write strobes (EPC, Cause, interrupt-enable) and stalls/redirects the fetch stage to the handler vector or back to the saved EPC.
- Sits between the core pipeline control and coprocessor 0.

Parameters:
- NUM_IRQ, 4, number of external interrupt lines (1..8).
- VECTOR_ADDR, 32'h0000_0008, handler entry PC for every exception/interrupt.
- SYSCALL_CAUSE, 5'd8, cause code written for a syscall.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- irq_i  in  NUM_IRQ  external interrupt lines, level, rising edge latched.
- pc_i  in  32  PC of the instruction at the commit boundary.
- pc_valid_i  in  1  pc_i is a legal exception boundary this cycle.
- syscall_i  in  1  syscall at the boundary (qualified by pc_valid_i).
- eret_i  in  1  eret at the boundary (qualified by pc_valid_i).
- int_en_i  in  1  global interrupt enable, read back from coprocessor reg 11 bit 0.
- epc_i  in  32  saved EPC read back from coprocessor.
- epc_w_o  out  32  PC value to save (coprocessor pc_i).
- cause_o  out  5  cause code (coprocessor InTcause).
- write_epc_o  out  1  EPC write strobe.
- write_cause_o  out  1  Cause write strobe.
- write_int_o  out  1  interrupt-enable write strobe.
- int_en_w_o  out  1  interrupt-enable value to write.
- stall_o  out  1  hold the pipeline.
- redirect_o  out  1  one-cycle fetch redirect.
- redirect_pc_o  out  32  redirect target.
- irq_ack_o  out  NUM_IRQ  one-hot, one-cycle acknowledge of the serviced line.

Behaviour:
- Clock and reset:
  - Single clock. Reset is synchronous and active-high.
  - On rst: state=IDLE, pending=0, irq_d=0, latched pc/cause=0.
  - Reset values of outputs: all strobes, stall_o, redirect_o and irq_ack_o are 0; epc_w_o=0; cause_o=0; redirect_pc_o=0; int_en_w_o=0.
  - rst mid-sequence aborts to IDLE with no further strobes.
- Pending logic:
  - pending[k] sets on the cycle irq_i[k]=1 and irq_d[k]=0; irq_d is the registered irq_i.
  - pending[k] clears on the irq_ack_o[k] cycle. If set and clear coincide, set wins.
- Selection: lowest index pending line wins. Cause for line k = 5'b10000 | k.
- IDLE, when pc_valid_i=1, priority is eret > syscall > irq:
  - eret_i: go to RET_EN.
  - syscall_i: latch pc_i+4 and SYSCALL_CAUSE; go to SAVE.
  - Otherwise, if any pending and int_en_i=1: latch pc_i and the selected cause/index; go to SAVE.
  - Outputs in IDLE are all 0 except that epc_w_o, cause_o and redirect_pc_o hold their last values.
- SAVE (1 cycle): write_epc_o=1, write_cause_o=1, epc_w_o=latched pc, cause_o=latched cause. Next state MASK.
- MASK (1 cycle): write_int_o=1, int_en_w_o=0. Next state JUMP.
- JUMP (1 cycle): redirect_o=1, redirect_pc_o=VECTOR_ADDR. If the entry was an irq, irq_ack_o=one-hot of the latched index. Next state IDLE.
- RET_EN (1 cycle): write_int_o=1, int_en_w_o=1. Next state RET_JUMP.
- RET_JUMP (1 cycle): redirect_o=1, redirect_pc_o=epc_i. Next state IDLE.
- stall_o=1 in every non-IDLE state and is combinationally 1 in IDLE on a cycle that takes a transition.
  - Entry latency: 3 cycles from acceptance to redirect.
  - Return latency: 2 cycles from acceptance to redirect.
- Arithmetic: pc_i+4 is a 32-bit add that wraps modulo 2^32.
- Boundary cases:
  - Inputs other than rst are ignored outside IDLE, but new irq edges still latch into pending.
  - With int_en_i=0, pending lines persist until enable returns.
  - The sequence never re-enters without returning to IDLE for at least 1 cycle.

Test Plan:
- Reset, then irq_i=4'b0100, int_en_i=1, pc_valid_i=1, pc_i=32'h100 -> SAVE: epc_w_o=32'h100, cause_o=5'h12; MASK: int_en_w_o=0; JUMP: redirect_pc_o=32'h8, irq_ack_o=4'b0100; stall_o high for 4 cycles.
- irq_i=4'b0110 rising together -> line 1 serviced first (cause 5'h11); line 2 stays pending and is taken after int_en_i returns to 1.
- syscall_i with pc_i=32'hFFFF_FFFC and irq pending -> syscall wins, epc_w_o=32'h0 (wrap), cause_o=5'd8, irq_ack_o stays 0.
- eret_i with epc_i=32'h204 and an irq pending in the same cycle -> RET_EN then RET_JUMP: write_int_o with int_en_w_o=1, redirect_pc_o=32'h204; no SAVE.
- int_en_i=0 with an irq edge -> no stall; raise int_en_i to 1 ten cycles later -> entry sequence starts on the next pc_valid_i.
- Assert rst during MASK -> next cycle all outputs 0, state IDLE, pending cleared.
